// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver for the shift-register link.
// Assembles WIDTH-bit words and hands them off on a one-entry valid/ready slot.
module shift_deserializer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_dir,
    input  logic             ser_valid,
    input  logic             ser_in,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overflow,
    output logic [CW-1:0]    bit_count
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             dir_lat;

    logic             accept;
    logic             cur_dir;
    logic             last_bit;
    logic             slot_free;
    logic [WIDTH-1:0] shifted;

    assign accept    = ser_valid & ~clear;
    // The first bit of a word uses the live direction; later bits the latched one.
    assign cur_dir   = (state == IDLE) ? shift_dir : dir_lat;
    assign last_bit  = (bit_count == LAST);
    assign slot_free = ~data_valid | data_ready;
    assign shifted   = cur_dir ? {sr[WIDTH-2:0], ser_in}
                               : {ser_in, sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sr         <= '0;
            bit_count  <= '0;
            dir_lat    <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            sr         <= '0;
            bit_count  <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (accept) begin
                if (state == IDLE) begin
                    dir_lat <= shift_dir;
                end
                if (last_bit) begin
                    state     <= IDLE;
                    sr        <= '0;
                    bit_count <= '0;
                    if (slot_free) begin
                        data_out   <= shifted;
                        data_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    state     <= ACCUM;
                    sr        <= shifted;
                    bit_count <= bit_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed scenarios plus random traffic
// compared against a bit-queue model of the receiver.
module tb_shift_deserializer;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          reset;
    logic          shift_dir;
    logic          ser_valid;
    logic          ser_in;
    logic          clear;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          data_ready;
    logic          overflow;
    logic [CW-1:0] bit_count;

    int n_checks = 0;
    int n_fail   = 0;

    bit           m_bits[$];
    bit           m_dir;
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_ovf;

    shift_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .shift_dir  (shift_dir),
        .ser_valid  (ser_valid),
        .ser_in     (ser_in),
        .clear      (clear),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overflow   (overflow),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b1;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, settle 1 ns past the edge.
    task automatic step(input bit sv, input bit b, input bit dir,
                        input bit rdy, input bit clr);
        logic [W-1:0] word;
        bit           free;
        ser_valid  = sv;
        ser_in     = b;
        shift_dir  = dir;
        data_ready = rdy;
        clear      = clr;
        if (clr) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            free = !m_valid || rdy;
            if (m_valid && rdy) m_valid = 1'b0;
            if (sv) begin
                if (m_bits.size() == 0) m_dir = dir;
                m_bits.push_back(b);
                if (m_bits.size() == W) begin
                    word = '0;
                    for (int i = 0; i < W; i++) begin
                        if (m_bits[i]) begin
                            if (m_dir) word = word | (W'(1) << (W - 1 - i));
                            else       word = word | (W'(1) << i);
                        end
                    end
                    m_bits.delete();
                    if (free) begin
                        m_data  = word;
                        m_valid = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] v, input bit dir,
                             input bit rdy);
        for (int i = 0; i < W; i++) begin
            step(1'b1, dir ? v[W-1-i] : v[i], dir, rdy, 1'b0);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        ser_valid  = 1'b0;
        ser_in     = 1'b0;
        shift_dir  = 1'b1;
        clear      = 1'b0;
        data_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", data_valid);
        end
        n_checks++;
        if (data_out !== '0 || overflow !== 1'b0 || bit_count !== '0) begin
            n_fail++;
            $display("FAIL reset_regs got out=%h ovf=%b cnt=%0d want 0/0/0",
                     data_out, overflow, bit_count);
        end
    endtask

    task automatic test_msb_first();
        bit b;
        for (int i = 0; i < W; i++) begin
            b = (i % 2) == 0;
            step(1'b1, b, 1'b1, 1'b1, 1'b0);
            if (i == W - 2) begin
                n_checks++;
                if (data_valid !== 1'b0 || bit_count !== CW'(W - 1)) begin
                    n_fail++;
                    $display("FAIL msb_pre got v=%b cnt=%0d want 0/%0d",
                             data_valid, bit_count, W - 1);
                end
            end
        end
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hAA) begin
            n_fail++;
            $display("FAIL msb_word got v=%b d=%h want 1/aa",
                     data_valid, data_out);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (data_valid !== 1'b0 || data_out !== 8'hAA) begin
            n_fail++;
            $display("FAIL msb_one_cycle got v=%b d=%h want 0/aa",
                     data_valid, data_out);
        end
    endtask

    task automatic test_lsb_dir_flip();
        logic [W-1:0] v;
        v = 8'h0F;
        send_word(8'hAA, 1'b0, 1'b1);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hAA) begin
            n_fail++;
            $display("FAIL lsb_word got v=%b d=%h want 1/aa",
                     data_valid, data_out);
        end
        for (int i = 0; i < W; i++) begin
            step(1'b1, v[i], (i >= 3), 1'b1, 1'b0);
        end
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h0F) begin
            n_fail++;
            $display("FAIL lsb_flip_ignored got v=%b d=%h want 1/0f",
                     data_valid, data_out);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        send_word(8'h3C, 1'b1, 1'b0);
        send_word(8'hC3, 1'b1, 1'b0);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h3C || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drop got v=%b d=%h ovf=%b want 1/3c/1",
                     data_valid, data_out, overflow);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (data_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_sticky got v=%b ovf=%b want 0/1",
                     data_valid, overflow);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || data_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL bp_clear got ovf=%b d=%h want 0/3c",
                     overflow, data_out);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] v;
        v = 8'h81;
        send_word(8'h55, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) begin
            step(1'b1, v[W-1-i], 1'b1, (i == W - 1), 1'b0);
        end
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h81 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simul got v=%b d=%h ovf=%b want 1/81/0",
                     data_valid, data_out, overflow);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] v;
        v = 8'h3B;
        for (int i = 0; i < 5; i++) step(1'b1, v[W-1-i], 1'b1, 1'b1, 1'b0);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bit_count !== '0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got cnt=%0d v=%b want 0/0",
                     bit_count, data_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_word(8'hF0, 1'b1, 1'b1);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hF0) begin
            n_fail++;
            $display("FAIL reset_residue got v=%b d=%h want 1/f0",
                     data_valid, data_out);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_gaps_clear();
        logic [W-1:0] v;
        logic [W-1:0] r;
        v = 8'h96;
        for (int i = 0; i < W; i++) begin
            step(1'b1, v[W-1-i], 1'b1, 1'b1, 1'b0);
            if (i != W - 1) begin
                repeat ($urandom_range(0, 3)) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            end
        end
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h96) begin
            n_fail++;
            $display("FAIL gaps got v=%b d=%h want 1/96", data_valid, data_out);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (bit_count !== '0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_partial got cnt=%0d v=%b want 0/0",
                     bit_count, data_valid);
        end
        r = W'($urandom);
        send_word(r, 1'b1, 1'b1);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== r) begin
            n_fail++;
            $display("FAIL clean_after_clear got v=%b d=%h want 1/%h",
                     data_valid, data_out, r);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
            n_checks++;
            if (data_valid !== m_valid || overflow !== m_ovf ||
                data_out !== m_data ||
                bit_count !== CW'(m_bits.size())) begin
                n_fail++;
                $display("FAIL rand_cyc%0d got v=%b o=%b d=%h c=%0d want v=%b o=%b d=%h c=%0d",
                         c, data_valid, overflow, data_out, bit_count,
                         m_valid, m_ovf, m_data, m_bits.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w[4];
        for (int k = 0; k < 4; k++) w[k] = W'($urandom);
        for (int k = 0; k < 4; k++) begin
            send_word(w[k], k[0], 1'b1);
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== w[k] || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_word%0d got v=%b d=%h o=%b want 1/%h/0",
                         k, data_valid, data_out, overflow, w[k]);
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_dir_flip();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_word();
        test_gaps_clear();
        test_back_to_back();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-in, parallel-out receiver: the far end of the 8-bit shift-register link. It accepts one bit per qualified clock, assembles WIDTH-bit words MSB-first or LSB-first, and presents each completed word on a one-entry output register with a valid/ready handshake. It sits between the serial line and the parallel consumer, and flags words lost to backpressure.

Parameters:
WIDTH, 8, word width in bits (WIDTH >= 2)
CW, $clog2(WIDTH), width of bit_count (3 for WIDTH=8)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
shift_dir  in  1  1 = MSB-first (left shift), 0 = LSB-first (right shift); sampled on first bit of each word
ser_valid  in  1  ser_in is valid this cycle
ser_in  in  1  serial data bit
clear  in  1  synchronous flush of partial word, output register and overflow
data_out  out  WIDTH  assembled word
data_valid  out  1  data_out holds an unconsumed word
data_ready  in  1  consumer accepts data_out this cycle
overflow  out  1  sticky: a completed word was dropped
bit_count  out  CW  bits accumulated in current partial word

Behaviour:
- reset low (async, any time): sr=0, bit_count=0, dir_lat=1, data_out=0, data_valid=0, overflow=0, state=IDLE. Partial word discarded; no word emitted on release.
- States: IDLE (bit_count==0) and ACCUM (0<bit_count<WIDTH). IDLE->ACCUM on accepted bit when WIDTH>1. ACCUM->IDLE on the WIDTH-th accepted bit or clear.
- Bit accepted on a rising edge when ser_valid=1 and clear=0.
- On an accepted bit in IDLE, dir_lat<=shift_dir; that bit uses the new shift_dir. shift_dir changes during ACCUM are ignored until the next word.
- MSB-first: sr <= {sr[WIDTH-2:0], ser_in}. LSB-first: sr <= {ser_in, sr[WIDTH-1:1]}.
- bit_count increments per accepted bit and wraps to 0 on the WIDTH-th bit.
- Word completion (WIDTH-th accepted bit): the assembled word is the shifted value including the current bit. On the same edge it goes to data_out if the slot is free. data_valid=1 from the next cycle, so latency is 1 clock from last bit sample to data_valid. sr is cleared on completion.
- Slot is free when data_valid=0, or when data_valid=1 and data_ready=1 in that cycle. A simultaneous consume and load keeps data_valid=1 with the new word and sets no overflow.
- Completion with the slot occupied and data_ready=0: the new word is dropped, data_out and data_valid are unchanged, and overflow<=1 (sticky).
- Handshake: when data_valid=1 and data_ready=1, the word is consumed at the edge and data_valid<=0 unless a new word loads on the same edge. data_out must hold stable while data_valid=1 and data_ready=0. data_ready is ignored when data_valid=0.
- data_out retains its last value after consumption; only data_valid qualifies it.
- clear=1 (sync, highest priority after reset): sr=0, bit_count=0, data_valid=0, overflow=0, state=IDLE. The bit present that cycle is not accepted and data_out is unchanged.
- ser_valid=0 gaps of any length inside a word are allowed; partial state holds.
- Back-to-back words with ser_valid held high are supported with no dead cycle between words.

Test Plan:
- MSB-first: shift_dir=1, bits 1,0,1,0,1,0,1,0 on consecutive cycles, data_ready=1 -> data_out=8'hAA, data_valid=1 for exactly 1 cycle, starting one cycle after the 8th bit.
- LSB-first: shift_dir=0, bits 0,1,0,1,0,1,0,1 -> data_out=8'hAA. Then flip shift_dir to 1 after bit 3 of the next word 1,1,1,1,0,0,0,0 (LSB-first) -> 8'h0F; the flip is ignored.
- Backpressure: data_ready=0, send 8'h3C then 8'hC3 -> data_out stays 8'h3C, overflow=1. Raise data_ready -> data_valid drops; overflow stays 1 until clear pulse -> 0.
- Simultaneous: word 8'h55 pending, data_ready=1 on the edge that completes 8'h81 -> data_valid stays 1, data_out=8'h81, overflow=0.
- Reset mid-word: 5 bits in, pull reset low asynchronously between edges -> bit_count=0, data_valid=0 immediately. Release and send 8'hF0 -> data_out=8'hF0 with no residue.
- Gaps and clear: 8'h96 with ser_valid=0 gaps of 0-3 cycles between bits -> 8'h96. A clear after 4 bits -> bit_count=0, and the next 8 bits form a clean word.
